// File: rtl/lathe_pkg.sv
// Mode encoding, debounce defaults and mode-request arbitration shared by the lathe panel front end.
package lathe_pkg;

  typedef enum logic [1:0] {
    MODE_NONE = 2'b00,
    MODE_AUTO = 2'b01,
    MODE_MAN  = 2'b10
  } mode_e;

  localparam int unsigned DEBOUNCE_CYCLES_SILICON = 500000;  // 10 ms at 50 MHz
  localparam int unsigned DEBOUNCE_CYCLES_SIM     = 4;
  localparam int unsigned CNT_W_DEFAULT           = 20;

  // MAN outranks AUTO when the selector reports both.
  function automatic mode_e requested_mode(input logic man_sel, input logic auto_sel);
    if (man_sel) return MODE_MAN;
    if (auto_sel) return MODE_AUTO;
    return MODE_NONE;
  endfunction

endpackage

// File: rtl/input_debounce.sv
// One panel channel: 2-flop synchroniser, run-length counter, stable flop.
// stable follows a clean raw step after 2 + DEBOUNCE_CYCLES edges; stable_nxt is its next-edge value.
module input_debounce
  import lathe_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SILICON,
  parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic stable_nxt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic             flip;

  // The counter never passes CNT_LAST: reaching it either flips or the input has already agreed.
  assign flip       = (sync2 != stable) && (cnt == CNT_LAST);
  assign stable_nxt = flip ? sync2 : stable;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1  <= raw;
      sync2  <= sync1;
      stable <= stable_nxt;
      if ((sync2 == stable) || flip) cnt <= '0;
      else                           cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lathe_input_conditioner.sv
// Panel front end: debounced start, MAN-over-AUTO mode with start interlock, start/mode pulses; all outputs registered.
// Define ESTOP_LATCH_EN to add the debounced e-stop fault latch; otherwise fault is tied 0.
module lathe_input_conditioner
  import lathe_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SILICON,
  parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_raw,
  input  logic       auto_raw,
  input  logic       man_raw,
  input  logic       estop_raw,
  input  logic       fault_clr,
  output logic       start_lvl,
  output logic       start_rise,
  output logic [1:0] mode,
  output logic       mode_chg,
  output logic       mode_blocked,
  output logic       fault
);

  logic  start_db, start_nxt;
  logic  auto_db, auto_nxt;
  logic  man_db, man_nxt;
  logic  fault_set, fault_lat;
  mode_e mode_q, mode_n, req_nxt;

  input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_start (
    .clk(clk), .rst(rst), .raw(start_raw), .stable(start_db), .stable_nxt(start_nxt)
  );
  input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_auto (
    .clk(clk), .rst(rst), .raw(auto_raw), .stable(auto_db), .stable_nxt(auto_nxt)
  );
  input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_man (
    .clk(clk), .rst(rst), .raw(man_raw), .stable(man_db), .stable_nxt(man_nxt)
  );

`ifdef ESTOP_LATCH_EN
  logic estop_db, estop_nxt;

  input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_estop (
    .clk(clk), .rst(rst), .raw(estop_raw), .stable(estop_db), .stable_nxt(estop_nxt)
  );

  assign fault_set = estop_nxt & ~estop_db;

  // A clear is honoured only once the e-stop is released and the spindle start is off.
  always_ff @(posedge clk) begin
    if (rst)                                       fault_lat <= 1'b0;
    else if (fault_set)                            fault_lat <= 1'b1;
    else if (fault_clr && !estop_db && !start_db)  fault_lat <= 1'b0;
  end
`else
  logic unused_estop;
  assign unused_estop = ^{estop_raw, fault_clr};
  assign fault_set    = 1'b0;
  assign fault_lat    = 1'b0;
`endif

  // Outputs are computed from next-edge debounced values so every output moves on the same edge as its cause.
  assign req_nxt = requested_mode(man_nxt, auto_nxt);

  always_comb begin
    mode_n = mode_q;
    if (fault_set || fault_lat) mode_n = MODE_NONE;
    else if (!start_db)         mode_n = req_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q       <= MODE_NONE;
      mode_chg     <= 1'b0;
      start_rise   <= 1'b0;
      mode_blocked <= 1'b0;
    end else begin
      mode_q       <= mode_n;
      mode_chg     <= (mode_n != mode_q);
      start_rise   <= start_nxt & ~start_db & (mode_n != MODE_NONE) & ~fault_set & ~fault_lat;
      mode_blocked <= start_nxt & (req_nxt != mode_n);
    end
  end

  assign start_lvl = start_db;
  assign mode      = mode_q;
  assign fault     = fault_lat;

endmodule

// File: tb/tb_lathe_input_conditioner.sv
// Directed vector bench for lathe_input_conditioner with DEBOUNCE_CYCLES=4.
module tb_lathe_input_conditioner;
  import lathe_pkg::*;

  logic       clk = 1'b0;
  logic       rst, start_raw, auto_raw, man_raw, estop_raw, fault_clr;
  logic       start_lvl, start_rise, mode_chg, mode_blocked, fault;
  logic [1:0] mode;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       s, a, m;
    int         n;
    logic [6:0] exp;
    string      name;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  lathe_input_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES_SIM), .CNT_W(20)) dut (
    .clk(clk), .rst(rst), .start_raw(start_raw), .auto_raw(auto_raw), .man_raw(man_raw),
    .estop_raw(estop_raw), .fault_clr(fault_clr), .start_lvl(start_lvl), .start_rise(start_rise),
    .mode(mode), .mode_chg(mode_chg), .mode_blocked(mode_blocked), .fault(fault)
  );

  // Expected output word: {start_lvl, start_rise, mode[1:0], mode_chg, mode_blocked, fault}
  function automatic logic [6:0] ex(input logic lvl, input logic rise, input logic [1:0] md,
                                    input logic chg, input logic blk, input logic flt);
    return {lvl, rise, md, chg, blk, flt};
  endfunction

  task automatic check(input string name, input logic [6:0] exp);
    logic [6:0] act;
    act = {start_lvl, start_rise, mode, mode_chg, mode_blocked, fault};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: lvl,rise,mode,chg,blk,fault got %b required %b", name, act, exp);
    end
  endtask

  task automatic apply(input logic s, input logic a, input logic m, input logic e, input logic c,
                       input int n, input string name, input logic [6:0] exp);
    start_raw = s; auto_raw = a; man_raw = m; estop_raw = e; fault_clr = c;
    repeat (n) @(posedge clk);
    @(negedge clk);
    check(name, exp);
  endtask

  task automatic add(input logic s, input logic a, input logic m, input int n,
                     input logic [6:0] exp, input string name);
    vec_t v;
    v.s = s; v.a = a; v.m = m; v.n = n; v.exp = exp; v.name = name;
    tbl.push_back(v);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bad;

    add(0, 1, 0, 5, ex(0, 0, 2'b00, 0, 0, 0), "auto_pre");
    add(0, 1, 0, 1, ex(0, 0, 2'b01, 1, 0, 0), "auto_set");
    add(0, 1, 0, 1, ex(0, 0, 2'b01, 0, 0, 0), "auto_chg_once");
    add(1, 1, 0, 5, ex(0, 0, 2'b01, 0, 0, 0), "start_pre");
    add(1, 1, 0, 1, ex(1, 1, 2'b01, 0, 0, 0), "start_rise");
    add(1, 1, 0, 1, ex(1, 0, 2'b01, 0, 0, 0), "rise_once");
    add(0, 1, 0, 5, ex(1, 0, 2'b01, 0, 0, 0), "release_pre");
    add(0, 1, 0, 1, ex(0, 0, 2'b01, 0, 0, 0), "release_done");
    add(0, 1, 1, 5, ex(0, 0, 2'b01, 0, 0, 0), "both_pre");
    add(0, 1, 1, 1, ex(0, 0, 2'b10, 1, 0, 0), "both_man");
    add(1, 1, 1, 6, ex(1, 1, 2'b10, 0, 0, 0), "man_start");
    add(1, 1, 0, 5, ex(1, 0, 2'b10, 0, 0, 0), "drop_man_pre");
    add(1, 1, 0, 1, ex(1, 0, 2'b10, 0, 1, 0), "blocked");
    add(1, 1, 0, 3, ex(1, 0, 2'b10, 0, 1, 0), "blocked_hold");
    add(0, 1, 0, 5, ex(1, 0, 2'b10, 0, 1, 0), "release2_pre");
    add(0, 1, 0, 1, ex(0, 0, 2'b10, 0, 0, 0), "release2_fall");
    add(0, 1, 0, 1, ex(0, 0, 2'b01, 1, 0, 0), "release2_mode");
    add(0, 1, 0, 1, ex(0, 0, 2'b01, 0, 0, 0), "release2_once");
    add(0, 0, 0, 6, ex(0, 0, 2'b00, 1, 0, 0), "to_none");
    add(1, 0, 0, 6, ex(1, 0, 2'b00, 0, 0, 0), "none_start");
    add(1, 0, 0, 1, ex(1, 0, 2'b00, 0, 0, 0), "none_no_rise");
    add(0, 0, 0, 6, ex(0, 0, 2'b00, 0, 0, 0), "none_release");
    add(1, 1, 0, 6, ex(1, 1, 2'b01, 1, 0, 0), "simultaneous");
    add(1, 1, 0, 1, ex(1, 0, 2'b01, 0, 0, 0), "simul_after");

    start_raw = 0; auto_raw = 0; man_raw = 0; estop_raw = 0; fault_clr = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset", ex(0, 0, 2'b00, 0, 0, 0));
    rst = 1'b0;

    foreach (tbl[i]) apply(tbl[i].s, tbl[i].a, tbl[i].m, 1'b0, 1'b0, tbl[i].n, tbl[i].name, tbl[i].exp);

    // Reset in the middle of an AUTO debounce must restart the full count.
    pulse_reset();
    check("reset_again", ex(0, 0, 2'b00, 0, 0, 0));
    rst = 1'b0;
    apply(0, 1, 0, 0, 0, 4, "partial_auto", ex(0, 0, 2'b00, 0, 0, 0));
    pulse_reset();
    check("reset_mid_count", ex(0, 0, 2'b00, 0, 0, 0));
    rst = 1'b0;
    apply(0, 1, 0, 0, 0, 5, "recount_pre", ex(0, 0, 2'b00, 0, 0, 0));
    apply(0, 1, 0, 0, 0, 1, "recount_done", ex(0, 0, 2'b01, 1, 0, 0));

    // Three-cycle start glitch in AUTO: no level change and no pulse at any point.
    bad = 1'b0;
    start_raw = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      bad = bad | start_lvl | start_rise;
    end
    start_raw = 1'b0;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      bad = bad | start_lvl | start_rise;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL glitch: start_lvl/start_rise got asserted required both 0 throughout");
    end

`ifdef ESTOP_LATCH_EN
    pulse_reset();
    rst = 1'b0;
    apply(0, 1, 0, 0, 0, 6, "es_auto", ex(0, 0, 2'b01, 1, 0, 0));
    apply(0, 1, 0, 1, 0, 6, "es_set", ex(0, 0, 2'b00, 1, 0, 1));
    apply(0, 1, 0, 1, 1, 1, "es_clr_ignored", ex(0, 0, 2'b00, 0, 0, 1));
    apply(0, 1, 0, 0, 0, 6, "es_released", ex(0, 0, 2'b00, 0, 0, 1));
    apply(0, 1, 0, 0, 1, 1, "es_clr_ok", ex(0, 0, 2'b00, 0, 0, 0));
    apply(0, 1, 0, 0, 0, 1, "es_mode_back", ex(0, 0, 2'b01, 1, 0, 0));
    apply(0, 1, 0, 1, 0, 6, "es_set2", ex(0, 0, 2'b00, 1, 0, 1));
    pulse_reset();
    check("es_reset", ex(0, 0, 2'b00, 0, 0, 0));
    rst = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
